// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and the sequencer state type.
package alu_pkg;

  localparam int unsigned AluOpw = 3;
  localparam int unsigned AluDw  = 16;

  localparam int unsigned OP_ADD     = 0;
  localparam int unsigned OP_SUB     = 1;
  localparam int unsigned OP_NOT     = 2;
  localparam int unsigned OP_AND     = 3;
  localparam int unsigned OP_OR      = 4;
  localparam int unsigned OP_XOR     = 5;
  localparam int unsigned OP_XNOR    = 6;
  localparam int unsigned OP_ILLEGAL = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLoad1,
    StLoad2,
    StExec,
    StWb,
    StErr
  } seq_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Free-running event counter that silently wraps from all-ones back to zero.
module wrap_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller stepping the register file and shared ALU through load, execute and
// writeback over the single internal bus. Outputs decode only registered state.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned OPW  = AluOpw,
  parameter int unsigned RSW  = 3,
  parameter int unsigned DW   = AluDw,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [RSW-1:0]  cmd_rs1,
  input  logic [RSW-1:0]  cmd_rs2,
  input  logic [RSW-1:0]  cmd_rd,
  input  logic [DW-1:0]   bus_i,
  output logic [RSW-1:0]  reg_sel,
  output logic            reg_rd_en,
  output logic            reg_wr_en,
  output logic            IN1_en,
  output logic            IN2_en,
  output logic [OPW-1:0]  OpControl,
  output logic            OUT_reg_en,
  output logic            OUT_en,
  output logic            done,
  output logic            err,
  output logic            zero,
  output logic [CNTW-1:0] ops_done
);

  seq_state_e     state_q;
  logic [OPW-1:0] op_q;
  logic [RSW-1:0] rs1_q, rs2_q, rd_q;
  logic           zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rs1_q   <= cmd_rs1;
            rs2_q   <= cmd_rs2;
            rd_q    <= cmd_rd;
            state_q <= (cmd_op == OPW'(OP_ILLEGAL)) ? StErr : StLoad1;
          end
        end
        // NOT has a single operand, so operand 2 is never fetched.
        StLoad1: state_q <= (op_q == OPW'(OP_NOT)) ? StExec : StLoad2;
        StLoad2: state_q <= StExec;
        StExec:  state_q <= StWb;
        StWb: begin
          zero_q  <= (bus_i == '0);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    OpControl  = (state_q == StIdle) ? '0 : op_q;
    reg_sel    = '0;
    reg_rd_en  = 1'b0;
    reg_wr_en  = 1'b0;
    IN1_en     = 1'b0;
    IN2_en     = 1'b0;
    OUT_reg_en = 1'b0;
    OUT_en     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      StLoad1: begin
        reg_sel   = rs1_q;
        reg_rd_en = 1'b1;
        IN1_en    = 1'b1;
      end
      StLoad2: begin
        reg_sel   = rs2_q;
        reg_rd_en = 1'b1;
        IN2_en    = 1'b1;
      end
      StExec: OUT_reg_en = 1'b1;
      StWb: begin
        reg_sel   = rd_q;
        reg_wr_en = 1'b1;
        OUT_en    = 1'b1;
        done      = 1'b1;
      end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  assign zero = zero_q;

  wrap_counter #(
    .Width (CNTW)
  ) u_ops_counter (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (state_q == StWb),
    .count_o (ops_done)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small register-file/ALU bus model around it.
module tb_alu_sequencer;

  localparam int unsigned OPW  = 3;
  localparam int unsigned RSW  = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned CNTW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_op;
  logic [RSW-1:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic [DW-1:0]   bus;
  logic [RSW-1:0]  reg_sel;
  logic            reg_rd_en, reg_wr_en, IN1_en, IN2_en, OUT_reg_en, OUT_en, done, err, zero;
  logic [OPW-1:0]  OpControl;
  logic [CNTW-1:0] ops_done;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] regs [8];
  logic [DW-1:0] alu_a, alu_b, alu_res;

  always #5 clk = ~clk;

  alu_sequencer #(
    .OPW  (OPW),
    .RSW  (RSW),
    .DW   (DW),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .bus_i      (bus),
    .reg_sel    (reg_sel),
    .reg_rd_en  (reg_rd_en),
    .reg_wr_en  (reg_wr_en),
    .IN1_en     (IN1_en),
    .IN2_en     (IN2_en),
    .OpControl  (OpControl),
    .OUT_reg_en (OUT_reg_en),
    .OUT_en     (OUT_en),
    .done       (done),
    .err        (err),
    .zero       (zero),
    .ops_done   (ops_done)
  );

  function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  assign bus = reg_rd_en ? regs[reg_sel] : (OUT_en ? alu_res : '0);

  always @(posedge clk) begin
    if (IN1_en)     alu_a <= bus;
    if (IN2_en)     alu_b <= bus;
    if (OUT_reg_en) alu_res <= alu_f(OpControl, alu_a, alu_b);
    if (reg_wr_en)  regs[reg_sel] <= bus;
  end

  // {cmd_ready, reg_rd_en, reg_wr_en, IN1_en, IN2_en, OUT_reg_en, OUT_en, done, err}
  function automatic logic [8:0] en_vec();
    return {cmd_ready, reg_rd_en, reg_wr_en, IN1_en, IN2_en, OUT_reg_en, OUT_en, done, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [8:0] en, input int sel, input int op);
    chk({tag, "_en"}, 32'(en_vec()), 32'(en));
    chk({tag, "_sel"}, 32'(reg_sel), sel);
    chk({tag, "_op"}, 32'(OpControl), op);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled every cycle: no bus contention, ready only when the sequencer is idle.
  always @(negedge clk) begin
    n_checks++;
    assert (!(reg_rd_en && OUT_en)) else begin
      n_fails++;
      $error("FAIL bus_contention observed=1 expected=0");
    end
    n_checks++;
    assert (!(cmd_ready && ((en_vec() & 9'h0FF) != 9'h000 || OpControl != '0))) else begin
      n_fails++;
      $error("FAIL ready_not_idle observed=0x%0h expected=0x100", en_vec());
    end
  end

  localparam logic [8:0] EnIdle  = 9'b1_0000_0000;
  localparam logic [8:0] EnLoad1 = 9'b0_1010_0000;
  localparam logic [8:0] EnLoad2 = 9'b0_1001_0000;
  localparam logic [8:0] EnExec  = 9'b0_0000_1000;
  localparam logic [8:0] EnWb    = 9'b0_0100_0110;
  localparam logic [8:0] EnErr   = 9'b0_0000_0001;

  initial begin
    int cyc;
    int dones;
    int ops_at_last;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    regs[3] = 16'hAAAA;
    regs[4] = 16'hFFFF;
    regs[5] = 16'h1234;
    regs[6] = 16'h5555;
    alu_a = '0; alu_b = '0; alu_res = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    repeat (2) tick();
    chk_cycle("reset", EnIdle, 0, 0);
    chk("reset_zero", 32'(zero), 0);
    chk("reset_ops", 32'(ops_done), 0);

    // Reset wins over a simultaneous command.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd3;
    tick();
    chk_cycle("rst_vs_valid", EnIdle, 0, 0);
    reset = 1'b0; cmd_valid = 1'b0;
    tick();
    chk_cycle("idle_after_rst", EnIdle, 0, 0);

    // ADD R3 = R1 + R2; command inputs scrambled mid-operation must be ignored.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd3;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd5; cmd_rs1 = 3'd6; cmd_rs2 = 3'd6; cmd_rd = 3'd6;
    chk_cycle("add_c1", EnLoad1, 1, 0);
    tick(); chk_cycle("add_c2", EnLoad2, 2, 0);
    tick(); chk_cycle("add_c3", EnExec, 0, 0);
    tick(); chk_cycle("add_c4", EnWb, 3, 0);
    tick(); chk_cycle("add_c5", EnIdle, 0, 0);
    chk("add_r3", 32'(regs[3]), 12);
    chk("add_zero", 32'(zero), 0);
    chk("add_ops", 32'(ops_done), 1);

    // NOT R5 = ~R4 skips operand 2 and yields zero.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rs1 = 3'd4; cmd_rs2 = 3'd1; cmd_rd = 3'd5;
    tick();
    cmd_valid = 1'b0;
    chk_cycle("not_c1", EnLoad1, 4, 2);
    tick(); chk_cycle("not_c2", EnExec, 0, 2);
    tick(); chk_cycle("not_c3", EnWb, 5, 2);
    tick(); chk_cycle("not_c4", EnIdle, 0, 0);
    chk("not_r5", 32'(regs[5]), 0);
    chk("not_zero", 32'(zero), 1);
    chk("not_ops", 32'(ops_done), 2);

    // Illegal opcode: single err pulse, nothing else moves.
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd6;
    tick();
    cmd_valid = 1'b0;
    chk_cycle("ill_c1", EnErr, 0, 7);
    tick(); chk_cycle("ill_c2", EnIdle, 0, 0);
    chk("ill_ops", 32'(ops_done), 2);
    chk("ill_zero_hold", 32'(zero), 1);
    chk("ill_r6", 32'(regs[6]), 32'h5555);

    // SUB aborted by reset during LOAD2.
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd6;
    tick();
    cmd_valid = 1'b0;
    chk_cycle("sub_c1", EnLoad1, 1, 1);
    tick(); chk_cycle("sub_c2", EnLoad2, 2, 1);
    reset = 1'b1;
    tick(); chk_cycle("sub_abort", EnIdle, 0, 0);
    chk("sub_abort_zero", 32'(zero), 0);
    chk("sub_abort_ops", 32'(ops_done), 0);
    reset = 1'b0;
    tick(); chk_cycle("sub_after", EnIdle, 0, 0);
    chk("sub_r6", 32'(regs[6]), 32'h5555);

    // Back-to-back XOR R7 = R1 ^ R2 until the 8-bit counter wraps.
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd7;
    cyc = 0; dones = 0; ops_at_last = -1;
    while (dones < 256 && cyc < 2000) begin
      tick();
      cyc++;
      if (done) begin
        dones++;
        if (dones == 256) ops_at_last = int'(ops_done);
      end
    end
    cmd_valid = 1'b0;
    chk("xor_dones", dones, 256);
    chk("xor_last_cycle", cyc, 1279);
    chk("xor_ops_before_wrap", ops_at_last, 255);
    tick();
    chk_cycle("xor_end", EnIdle, 0, 0);
    chk("xor_ops_wrap", 32'(ops_done), 0);
    chk("xor_r7", 32'(regs[7]), 2);
    chk("xor_zero", 32'(zero), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the shared 16-bit ALU over the CPU's single internal bus. It accepts one operation command at a time (opcode plus source and destination register indices). It then steps the register file and the ALU enables through operand load, execute, and writeback. It reports completion, a result-zero flag and a running count of completed operations.

## Interface
Parameters:
- `OPW`, 3, opcode width; must match ALU `OpControl`.
- `RSW`, 3, register-index width (8 registers).
- `DW`, 16, bus/data width.
- `CNTW`, 16, completed-operation counter width.

Ports:
- `clk`  in  1  system clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  OPW  ALU opcode.
- `cmd_rs1`  in  RSW  first operand register.
- `cmd_rs2`  in  RSW  second operand register; ignored for NOT.
- `cmd_rd`  in  RSW  destination register.
- `bus_i`  in  DW  shared bus, sampled for the zero flag.
- `reg_sel`  out  RSW  register-file index.
- `reg_rd_en`  out  1  register file drives the bus.
- `reg_wr_en`  out  1  register file captures the bus.
- `IN1_en`  out  1  ALU captures operand 1.
- `IN2_en`  out  1  ALU captures operand 2.
- `OpControl`  out  OPW  ALU operation select.
- `OUT_reg_en`  out  1  ALU captures its result internally.
- `OUT_en`  out  1  ALU drives its result onto the bus.
- `done`  out  1  one-cycle pulse at writeback.
- `err`  out  1  one-cycle pulse for an illegal opcode.
- `zero`  out  1  last result was zero.
- `ops_done`  out  CNTW  number of completed operations.

## Operation
- Opcodes: ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, XNOR=6. Opcode 7 is illegal.
- FSM states: IDLE, LOAD1, LOAD2, EXEC, WB, ERR.
- Accept: in IDLE, `cmd_ready`=1. When `cmd_valid` is high, the command is latched into internal op/rs1/rs2/rd registers.
- Next state after accept: LOAD1, or ERR if opcode is 7.
- LOAD1: `reg_sel`=rs1, `reg_rd_en`=1, `IN1_en`=1. Next state is LOAD2, or EXEC if op is NOT.
- LOAD2: `reg_sel`=rs2, `reg_rd_en`=1, `IN2_en`=1. Next state EXEC.
- EXEC: `OUT_reg_en`=1. Next state WB.
- WB: `OUT_en`=1, `reg_sel`=rd, `reg_wr_en`=1, `done`=1. `zero` is set to (`bus_i`==0). `ops_done` increments. Next state IDLE.
- ERR: `err`=1; no bus or register activity. Next state IDLE. `ops_done` is unchanged.
- `OpControl` equals the latched op in every non-IDLE state, and 0 in IDLE.
- All enables are 0 in IDLE, and in any state not listed above.
- `reg_sel`=0 whenever no read or write is active.
- `reg_rd_en` and `OUT_en` are never high in the same cycle; this is the bus-contention invariant.
- `ops_done` wraps from all-ones to 0 with no flag.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, all enables 0, `OpControl`=0, `done`=0, `err`=0, `zero`=0, `ops_done`=0, latched command fields 0.
- Outputs are a decode of the registered state and latched fields only; there is no combinational path from `cmd_*` to any output. `cmd_ready` depends on state only.
- Latency, counting the accept edge as cycle 0:
  - Two-operand op: LOAD1 in cycle 1, LOAD2 in 2, EXEC in 3, WB (`done`) in 4. `cmd_ready` is high again in cycle 5.
  - NOT: `done` in cycle 3.
  - Illegal opcode: `err` in cycle 1, ready in cycle 2.
- Throughput: one command per 5 cycles (4 for NOT, 2 for illegal). Back-to-back `cmd_valid` is accepted on the first IDLE cycle.
- `cmd_*` changes while not IDLE are ignored.
- Reset mid-operation: the next cycle is IDLE with all enables 0. No `done`, no `err`, and no `ops_done` change for the aborted command.
- Reset asserted together with `cmd_valid`: reset wins and the command is not accepted.
- `zero` holds its value until the next WB.

## Structure
- Package `alu_pkg`:
  - opcode localparams ADD..XNOR and OP_ILLEGAL=7;
  - FSM state typedef;
  - `DW`/`OPW` defaults, shared with the ALU.
- No sub-module is needed: a single FSM plus command latch and counter. The counter may optionally be a separate `wrap_counter` sub-module for reuse.

## Test plan
- Reset, then ADD with rs1=1, rs2=2, rd=3, where the bus model gives R1=5, R2=7 → cycles 1–4 show LOAD1/LOAD2/EXEC/WB enables exactly as specified; R3=12; `done` in cycle 4; `zero`=0; `ops_done`=1.
- NOT with rs1=4 (R4=0xFFFF), rd=5 → LOAD2 is skipped; `done` in cycle 3; R5=0x0000; `zero`=1.
- Opcode 7 → `err` pulse in cycle 1; no enable ever high; `ops_done` unchanged; ready in cycle 2.
- `reset` asserted during LOAD2 of a SUB → next cycle IDLE with all outputs at reset values; no `done`.
- 65 536 back-to-back XOR commands with `cmd_valid` held high → `ops_done` wraps to 0. An assertion checks `reg_rd_en & OUT_en` is never 1, and `cmd_ready` is high only in IDLE.
